// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw button inputs and conditioned level/event outputs
interface button_conditioner_if #(parameter int NUM_BTNS = 3);
  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_press;
  logic [NUM_BTNS-1:0] btn_release;
  logic [NUM_BTNS-1:0] btn_long;
  logic [NUM_BTNS-1:0] btn_short;
  modport master (output btn_raw, input btn_level, btn_press, btn_release, btn_long, btn_short);
  modport slave (input btn_raw, output btn_level, btn_press, btn_release, btn_long, btn_short);
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: per-button synchroniser, debouncer and press/release/long/short event generator
module button_conditioner #(
  parameter int          NUM_BTNS          = 3,
  parameter logic [23:0] DEBOUNCE_CYCLES   = 24'd100_000,
  parameter logic [23:0] LONG_PRESS_CYCLES = 24'd10_000_000
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    logic r_s1, r_s2, r_level, r_press, r_release, r_long, r_short;
    logic [23:0] r_db_cnt, r_hold_cnt, w_hold_nxt;
    state_t r_state, w_state_nxt;
    logic w_flip, w_rise, w_fall, w_long, w_short;
    assign w_flip = (r_s2 != r_level) && (r_db_cnt == DEBOUNCE_CYCLES - 24'd1);
    assign w_rise = w_flip & r_s2;
    assign w_fall = w_flip & ~r_s2;
    // a release coinciding with the long threshold wins and reports a short press
    always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold_cnt;
      w_long      = 1'b0;
      w_short     = 1'b0;
      if (w_rise) begin
        w_state_nxt = HELD;
        w_hold_nxt  = '0;
      end else if (r_state == HELD) begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          w_short     = 1'b1;
        end else if (r_hold_cnt == LONG_PRESS_CYCLES - 24'd1) begin
          w_state_nxt = LONG;
          w_long      = 1'b1;
        end else begin
          w_hold_nxt = r_hold_cnt + 24'd1;
        end
      end else if (r_state == LONG && w_fall) begin
        w_state_nxt = IDLE;
      end
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        r_s1       <= 1'b0;
        r_s2       <= 1'b0;
        r_level    <= 1'b0;
        r_db_cnt   <= '0;
        r_hold_cnt <= '0;
        r_state    <= IDLE;
        r_press    <= 1'b0;
        r_release  <= 1'b0;
        r_long     <= 1'b0;
        r_short    <= 1'b0;
      end else begin
        r_s1       <= bus.btn_raw[i];
        r_s2       <= r_s1;
        r_db_cnt   <= (r_s2 == r_level || w_flip) ? '0 : r_db_cnt + 24'd1;
        r_level    <= w_flip ? r_s2 : r_level;
        r_hold_cnt <= w_hold_nxt;
        r_state    <= w_state_nxt;
        r_press    <= w_rise;
        r_release  <= w_fall;
        r_long     <= w_long;
        r_short    <= w_short;
      end
    end
    assign bus.btn_level[i]   = r_level;
    assign bus.btn_press[i]   = r_press;
    assign bus.btn_release[i] = r_release;
    assign bus.btn_long[i]    = r_long;
    assign bus.btn_short[i]   = r_short;
  end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-conditioning stage between the raw pushbuttons on `ui_in` and the counter/display logic of the Tamagotchi design. Each of `NUM_BTNS` active-high button inputs is synchronised, debounced and turned into a clean level plus single-cycle press, release, long-press and short-press events. The counter/seven-segment stage downstream consumes only these conditioned signals, never raw pins.

## Interface
- `NUM_BTNS`, 3: number of independent button channels (1..8).
- `DEBOUNCE_CYCLES`, 24'd100_000: consecutive cycles of a changed synchronised input needed to change the debounced level (10 ms at 10 MHz); legal 2..2^24-1.
- `LONG_PRESS_CYCLES`, 24'd10_000_000: cycles after a press event at which the long-press event fires (1 s at 10 MHz); legal 2..2^24-1.
- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `btn_raw` input NUM_BTNS: asynchronous raw buttons, 1 = pressed.
- `btn_level` output NUM_BTNS: debounced level per button.
- `btn_press` output NUM_BTNS: 1-cycle pulse on debounced 0->1.
- `btn_release` output NUM_BTNS: 1-cycle pulse on debounced 1->0.
- `btn_long` output NUM_BTNS: 1-cycle pulse when held LONG_PRESS_CYCLES after press.
- `btn_short` output NUM_BTNS: 1-cycle pulse coincident with release when `btn_long` did not fire during that press.

## Operation
- Channels are fully independent; identical logic replicated per bit.
- Synchroniser: two flops (`s1`, `s2`) per channel; only `s2` is used downstream.
- Debounce: 24-bit counter `db_cnt`. Per cycle: if `s2 == btn_level` -> `db_cnt <= 0`. Else if `db_cnt == DEBOUNCE_CYCLES-1` -> `btn_level <= s2`, `db_cnt <= 0`, fire press (new level 1) or release (new level 0). Else `db_cnt <= db_cnt + 1`.
- Any bounce back to the current level before the count completes restarts the count; pulses narrower than DEBOUNCE_CYCLES at `s2` produce no event.
- Per-channel state machine: IDLE (level 0) -> HELD on press; HELD -> LONG on `btn_long`; HELD -> IDLE on release (fires `btn_short`); LONG -> IDLE on release (no `btn_short`).
- Hold counter `hold_cnt` (24-bit): cleared on press event; increments every cycle in HELD; `btn_long` fires when it reaches LONG_PRESS_CYCLES-1 with state HELD, moving to LONG; counter frozen in LONG and IDLE. No wrap-around possible.
- `btn_long` fires at most once per press; no auto-repeat.
- Press and release of one channel are never asserted in the same cycle; `btn_short` and `btn_release` are always coincident; `btn_long` and `btn_release` are mutually exclusive in a cycle (release wins: if release and long-threshold coincide, release + short fire, no long).
- All outputs registered.

## Timing
- Reset (synchronous, evaluated at rising edge): `s1`, `s2`, `btn_level`, all counters -> 0, state -> IDLE; all outputs 0 in the cycle after the reset edge. Reset while a button is held clears the level with no release/short pulse; after reset deassertion a still-held button produces a fresh press after normal latency.
- Press latency: `btn_raw` stable high before edge E -> `btn_level` and `btn_press` high from edge E+1+DEBOUNCE_CYCLES (i.e. DEBOUNCE_CYCLES+2 cycles after first sampling edge, counting E). Release identical.
- `btn_press`, `btn_release`, `btn_short`, `btn_long` each exactly one cycle wide.
- `btn_long` rises exactly LONG_PRESS_CYCLES cycles after the rising edge that raised `btn_press`.
- Minimum repeat: next event on a channel no earlier than DEBOUNCE_CYCLES cycles after the previous one.

## Test plan
Bench parameters: NUM_BTNS=3, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
- Clean press: raise `btn_raw[0]` before edge 10, hold -> `btn_level[0]`/`btn_press[0]` high after edge 15, press pulse 1 cycle; `btn_long[0]` single pulse after edge 35; drop input -> `btn_release[0]` pulse 6 cycles later, `btn_short[0]` stays 0.
- Short press: hold `btn_raw[1]` 10 cycles -> one press, one release + `btn_short[1]` coincident, no `btn_long[1]`.
- Bounce: toggle `btn_raw[2]` high 3 cycles / low 1 cycle repeatedly for 20 cycles then low -> no events, `btn_level[2]` stays 0; then high 4+ stable cycles -> exactly one press.
- Independence: press buttons 0 and 2 simultaneously, release 0 early -> each channel's events at their own computed edges, channel 1 silent.
- Reset mid-hold: button 0 held (level 1, in LONG), assert `reset` 1 cycle -> all outputs 0 next cycle, no release pulse; button still held -> new `btn_press[0]` 6 cycles after reset deasserts.
- Release at long threshold: release timed so debounced fall lands on the long-threshold cycle -> `btn_release` + `btn_short` fire, `btn_long` never fires.
